// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state encoding and count-direction constants for the counter sequencer.
package count_ctrl_pkg;

    typedef enum logic [2:0] {INIT, IDLE, LOAD, RUN, DONE} state_t;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

endpackage

// File: rtl/count_ctrl_timer.sv
// count_ctrl_timer: RUN-state cycle counter that saturates and flags expiry at LIMIT.
module count_ctrl_timer #(
    parameter  int LIMIT = 32,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    assign expired = cnt == W'(LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/up_down_sync_loadable_counter.sv
// up_down_sync_loadable_counter: counter with sync active-high reset, parallel load and up/down step.
module up_down_sync_loadable_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode_cntrl,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= rst ? '0 : load ? din : mode_cntrl ? dout + 1'b1 : dout - 1'b1;
    end

endmodule

// File: rtl/up_down_count_ctrl.sv
// up_down_count_ctrl: loads a counter from a command, runs it and freezes it on target/abort.
// COUNT_CTRL_TIMEOUT_EN adds a RUN-cycle timeout reported through done_err.
module up_down_count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             cmd_up,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             done_abort,
    output logic             done_err,
    output logic             cnt_rst,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_din,
    input  logic [WIDTH-1:0] cnt_dout
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] start_q, target_q;
    logic             mode_q, abort_q, timeout_q;
    logic             match, timeout, stop;

    assign match = cnt_dout == target_q;
    assign stop  = (state == RUN) && (match || abort || timeout);

`ifdef COUNT_CTRL_TIMEOUT_EN
    count_ctrl_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == LOAD),
        .en      (state == RUN),
        .expired (timeout)
    );
`else
    logic unused_tmo;
    assign unused_tmo = TIMEOUT_CYC > 0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            start_q   <= '0;
            target_q  <= '0;
            mode_q    <= MODE_DOWN;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_valid && cmd_ready) begin
                start_q  <= cmd_start;
                target_q <= cmd_target;
                mode_q   <= cmd_up;
            end
            // match outranks abort, abort outranks timeout
            if (stop) begin
                abort_q   <= !match && abort;
                timeout_q <= !match && !abort && timeout;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        done_abort = 1'b0;
        done_err   = 1'b0;
        cnt_rst    = 1'b0;
        cnt_load   = 1'b1;
        cnt_mode   = mode_q;
        cnt_din    = cnt_dout;
        case (state)
            INIT: begin
                state_nxt = IDLE;
                cnt_rst   = 1'b1;
                cnt_load  = 1'b0;
                cnt_mode  = MODE_DOWN;
                cnt_din   = '0;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                state_nxt = cmd_valid ? LOAD : IDLE;
            end
            LOAD: begin
                busy      = 1'b1;
                cnt_din   = start_q;
                state_nxt = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                cnt_load  = stop;
                state_nxt = stop ? DONE : RUN;
            end
            DONE: begin
                done       = 1'b1;
                done_abort = abort_q;
                done_err   = timeout_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

endmodule
